// File: rtl/ws2812b_meter_scheduler.sv
// Frame scheduler for the WS2812B VU meter: tracks per-frame peak level, scales it to an
// LED count with release decay and peak-hold, then hands the frame to the strip driver.
module ws2812b_meter_scheduler #(
    parameter int          LEVEL_W      = 8,
    parameter logic [15:0] FRAME_CYCLES = 16'd50000,
    parameter int          DECAY        = 2,
    parameter int          HOLD_FRAMES  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               level_valid,
    input  logic [LEVEL_W-1:0] level,
    output logic               level_ready,
    input  logic [15:0]        maxCount,
    output logic               meter_enable,
    output logic               meter_start,
    input  logic               meter_done,
    output logic [15:0]        onCount,
    output logic [15:0]        peakIndex,
    output logic               overrun
);

    localparam int          PROD_W  = LEVEL_W + 17;
    localparam int          HOLD_W  = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam logic [15:0] DECAY_V = 16'(DECAY);

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        SCALE,
        UPDATE,
        START,
        WAIT_DONE
    } state_t;

    state_t              state;
    logic [15:0]         frame_cnt;
    logic [LEVEL_W-1:0]  acc;
    logic [LEVEL_W-1:0]  pk;
    logic [15:0]         scaled;
    logic [15:0]         max_lat;
    logic [HOLD_W-1:0]   hold_cnt;

    logic                tick;
    logic [LEVEL_W-1:0]  acc_upd;
    logic [LEVEL_W-1:0]  acc_fresh;
    logic [PROD_W-1:0]   prod;
    logic [PROD_W-1:0]   shifted;
    logic [15:0]         scaled_next;
    logic [15:0]         on_dec;
    logic [15:0]         on_next;
    logic [15:0]         peak_next;
    logic [HOLD_W-1:0]   hold_next;

    assign level_ready = ~reset;
    assign tick        = (state != IDLE) && (frame_cnt == 16'd0);
    assign acc_upd     = (level_valid && (level > acc)) ? level : acc;
    // The sample arriving on the tick cycle opens the next frame's peak.
    assign acc_fresh   = level_valid ? level : '0;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        prod        = PROD_W'(pk) * PROD_W'({1'b0, maxCount} + 17'd1);
        shifted     = prod >> LEVEL_W;
        scaled_next = (shifted > PROD_W'(maxCount)) ? maxCount : shifted[15:0];

        on_dec  = (onCount > DECAY_V) ? onCount - DECAY_V : 16'd0;
        on_next = (scaled >= onCount) ? scaled : ((scaled > on_dec) ? scaled : on_dec);
        if (on_next > max_lat)
            on_next = max_lat;

        peak_next = peakIndex;
        hold_next = hold_cnt;
        if (on_next >= peakIndex) begin
            peak_next = on_next;
            hold_next = HOLD_W'(HOLD_FRAMES);
        end else if (hold_cnt != '0) begin
            hold_next = hold_cnt - 1'b1;
        end else begin
            // peakIndex > on_next here, so the decrement cannot wrap.
            peak_next = ((peakIndex - 16'd1) > on_next) ? peakIndex - 16'd1 : on_next;
        end
        if (peak_next > max_lat)
            peak_next = max_lat;
    end

    // NOTE: sequential state uses non-blocking assignments only; async reset clears every register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            frame_cnt    <= FRAME_CYCLES - 16'd1;
            acc          <= '0;
            pk           <= '0;
            scaled       <= 16'd0;
            max_lat      <= 16'd0;
            hold_cnt     <= '0;
            onCount      <= 16'd0;
            peakIndex    <= 16'd0;
            overrun      <= 1'b0;
            meter_enable <= 1'b0;
            meter_start  <= 1'b0;
        end else begin
            meter_start <= 1'b0;

            if (state == IDLE || tick)
                frame_cnt <= FRAME_CYCLES - 16'd1;
            else
                frame_cnt <= frame_cnt - 16'd1;

            if (state == IDLE)
                acc <= '0;
            else
                acc <= acc_upd;

            case (state)
                IDLE: begin
                    if (run) begin
                        state        <= ACCUM;
                        meter_enable <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (tick) begin
                        pk    <= acc;
                        acc   <= acc_fresh;
                        state <= SCALE;
                    end else if (!run) begin
                        state        <= IDLE;
                        meter_enable <= 1'b0;
                    end
                end
                SCALE: begin
                    scaled  <= scaled_next;
                    max_lat <= maxCount;
                    state   <= UPDATE;
                end
                UPDATE: begin
                    onCount     <= on_next;
                    peakIndex   <= peak_next;
                    hold_cnt    <= hold_next;
                    meter_start <= 1'b1;
                    state       <= START;
                end
                START: begin
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (meter_done) begin
                        if (tick) begin
                            pk    <= acc;
                            acc   <= acc_fresh;
                            state <= SCALE;
                        end else if (run) begin
                            state <= ACCUM;
                        end else begin
                            state        <= IDLE;
                            meter_enable <= 1'b0;
                        end
                    end else if (tick) begin
                        // Driver still busy: skip this frame and keep accumulating.
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    meter_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule
